mod_check_scheduler: RTL
========================

Name: mod_check_scheduler

Overview:
Shares one serial modulo-DIVISOR residue engine between NUM_REQ requesters. Round-robin arbitration picks one parallel word, which is shifted MSB-first through the residue engine over WIDTH cycles. The block then returns a result: divisible flag, remainder and requester id, on a valid/ready result channel. It sits between parallel-word producers and the divisibility-check consumer, replacing per-requester serial FSMs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data word width in bits (>=1)
DIVISOR, 5, modulus (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester word valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_data_i  in  NUM_REQ*WIDTH  requester k word at bits [k*WIDTH +: WIDTH]
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumer ready
res_id_o  out  $clog2(NUM_REQ)  index of served requester
res_divisible_o  out  1  1 when word mod DIVISOR == 0
res_remainder_o  out  $clog2(DIVISOR)  word mod DIVISOR
busy_o  out  1  high in SHIFT or DONE

Behaviour:
- Reset: clk and rst_n are the ports; reset is synchronous and active-low. While rst_n=0 at a clk edge: state=IDLE, residue=0, shift reg=0, bit count=0, rr pointer=0 (requester 0 highest priority). Outputs after reset: res_valid_o=0, req_ready_o=0, res_id_o=0, res_divisible_o=0, res_remainder_o=0, busy_o=0. A reset mid-operation discards the job; the word is not replayed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready_o is combinational: one-hot for the first valid requester found searching from the rr pointer upward, with wrap.
  - On the accepting edge T: latch the word, latch the id, clear the residue, bit count=0, go to SHIFT.
  - The rr pointer becomes (granted id + 1) mod NUM_REQ.
  - With no valid requester: stay in IDLE.
- SHIFT:
  - One bit per cycle, MSB first.
  - Residue update: r <= (2*r + bit) mod DIVISOR, computed as a conditional subtract on a $clog2(DIVISOR)+1 bit value. No full-width divider.
  - After WIDTH bits (edge T+WIDTH), go to DONE.
  - req_ready_o=0 throughout SHIFT.
- DONE:
  - res_valid_o=1 from cycle T+WIDTH+1. Result latency is WIDTH+1 cycles after acceptance.
  - res_remainder_o=residue, res_divisible_o=(residue==0), res_id_o=latched id.
  - All result outputs stay stable until res_valid_o & res_ready_i; then go to IDLE.
  - No new grant in DONE. Back-to-back jobs have one IDLE cycle between them.
- Requester handshake: a word transfers when req_valid_i[k] & req_ready_o[k]. Requesters must hold data stable while valid and not yet accepted.
- Simultaneous valids: exactly one grant. The losing requester keeps valid and is served next, in rr order.
- Boundary cases:
  - WIDTH=1 gives a single SHIFT cycle.
  - Data 0 gives remainder 0.
  - Data all-ones is handled without overflow.
  - Non-power-of-2 NUM_REQ wraps the pointer correctly.
  - res_ready_i held high in DONE: the result is consumed in its first valid cycle.

Optional Feature:
MOD_SCHED_STATS_EN
- Defined:
  - Adds output ports jobs_done_o (16 bits) and jobs_div_o (16 bits), cleared by reset.
  - Each increments on a result handshake; jobs_div_o increments only when res_divisible_o=1.
  - Both wrap at 2^16.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mod_sched_pkg: state_t enum (IDLE, SHIFT, DONE); default parameter constants; function residue_step(r, bit, divisor).
- Sub-module mod_residue_step: registered residue with clear and shift_en inputs, serial bit input, and residue output. It is the generalized serial residue tracker.
- Arbiter stays inline in the top level: rr pointer plus priority search.

Test Plan:
- Single job, requester 0, data 8'd35, res_ready_i=1 -> res_valid_o rises 9 cycles after acceptance; divisible=1, remainder=0, id=0.
- Requester 2, data 8'd37 -> remainder=2, divisible=0, id=2. Then data 8'hFF -> remainder=0, divisible=1.
- Requesters 0 and 1 valid together, repeated 3 jobs each -> grant order 0,1,0,1,0,1. req_ready_o is never multi-hot.
- res_ready_i low for 5 cycles in DONE -> result outputs stable, req_ready_o=0 and no grant; the handshake on cycle 6 returns the FSM to IDLE.
- rst_n=0 for one clock at SHIFT bit 4 -> next cycle IDLE, all outputs 0. A following request from requester 3 with requester 0 also valid -> requester 0 is granted (pointer reset).
- With MOD_SCHED_STATS_EN defined: run jobs 10, 11, 15, 0 -> jobs_done_o=4, jobs_div_o=3.

Source files
------------

// File: rtl/mod_sched_pkg.sv
// Shared types, default parameters and the serial residue step for the modulo-check scheduler.
package mod_sched_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_DIVISOR = 5;
    localparam int unsigned STATS_W     = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // (2*r + b) mod divisor for r < divisor: the doubled value is below 2*divisor, so one subtract suffices
    function automatic logic [15:0] residue_step(input logic [15:0] r, input logic b,
                                                 input logic [15:0] divisor);
        logic [15:0] v;
        v = {r[14:0], b};
        return (v >= divisor) ? (v - divisor) : v;
    endfunction

endpackage

// File: rtl/mod_residue_step.sv
// Serial MSB-first residue tracker: clear starts a word, shift_en folds in one bit per cycle.
module mod_residue_step
    import mod_sched_pkg::*;
#(
    parameter int unsigned DIVISOR = DEF_DIVISOR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_shift_en,
    input  logic                       i_bit,
    output logic [$clog2(DIVISOR)-1:0] o_residue
);

    localparam int unsigned RW = $clog2(DIVISOR);

    logic [RW-1:0] r_residue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_residue <= '0;
        end else if (i_clear) begin
            r_residue <= '0;
        end else if (i_shift_en) begin
            r_residue <= RW'(residue_step(16'(r_residue), i_bit, 16'(DIVISOR)));
        end
    end

    assign o_residue = r_residue;

endmodule

// File: rtl/mod_check_scheduler.sv
// Round-robin shared modulo-DIVISOR checker: one serial residue engine, valid/ready result channel.
// Optional MOD_SCHED_STATS_EN adds 16-bit job / divisible-job counters.
module mod_check_scheduler
    import mod_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DIVISOR = DEF_DIVISOR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] res_id_o,
    output logic                       res_divisible_o,
    output logic [$clog2(DIVISOR)-1:0] res_remainder_o,
`ifdef MOD_SCHED_STATS_EN
    output logic [STATS_W-1:0]         jobs_done_o,
    output logic [STATS_W-1:0]         jobs_div_o,
`endif
    output logic                       busy_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned RW = $clog2(DIVISOR);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    w_gid;
    logic [WIDTH-1:0] w_word;
    logic             w_found;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_res_fire;
    logic [RW-1:0]    w_residue;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        logic [IW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_gid   = '0;
        w_word  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_idx = IW'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid_i[v_idx]) begin
                w_found = 1'b1;
                w_gid   = v_idx;
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gid == IW'(k)) begin
                w_word = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept   = (r_state == IDLE) && w_found;
    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));
    assign w_res_fire = (r_state == DONE) && res_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SHIFT;
                    req_ready_o = NUM_REQ'(1) << w_gid;
                end
            end
            SHIFT:   if (w_last_bit) w_state_nxt = DONE;
            DONE:    if (res_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id    <= w_gid;
                r_shift <= w_word;
                r_cnt   <= '0;
                r_ptr   <= (w_gid == IW'(NUM_REQ - 1)) ? '0 : w_gid + IW'(1);
            end else if (r_state == SHIFT) begin
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    mod_residue_step #(
        .DIVISOR (DIVISOR)
    ) u_residue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept),
        .i_shift_en (r_state == SHIFT),
        .i_bit      (r_shift[WIDTH-1]),
        .o_residue  (w_residue)
    );

    assign res_valid_o     = (r_state == DONE);
    assign res_remainder_o = w_residue;
    assign res_divisible_o = (r_state == DONE) && (w_residue == '0);
    assign res_id_o        = r_id;
    assign busy_o          = (r_state != IDLE);

`ifdef MOD_SCHED_STATS_EN
    logic [STATS_W-1:0] r_jobs_done;
    logic [STATS_W-1:0] r_jobs_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_jobs_done <= '0;
            r_jobs_div  <= '0;
        end else if (w_res_fire) begin
            r_jobs_done <= r_jobs_done + STATS_W'(1);
            if (res_divisible_o) r_jobs_div <= r_jobs_div + STATS_W'(1);
        end
    end

    assign jobs_done_o = r_jobs_done;
    assign jobs_div_o  = r_jobs_div;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_res_fire;
`endif

endmodule
